// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: walks the enabled descriptor slots through the read and write streamers,
// never letting a write overtake its read. The optional watchdog is built with DMA_SCHED_WATCHDOG_EN.
module dma_desc_sched #(
  parameter int unsigned NUM_DESC = 4,
  parameter int unsigned BYTES_W  = 32,
  parameter int unsigned IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1,
  parameter int unsigned WDOG_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go_i,
  input  logic                        abort_req_i,
  input  logic                        err_stop_i,
  input  logic [NUM_DESC-1:0]         desc_en_i,
  input  logic [NUM_DESC*BYTES_W-1:0] desc_bytes_i,
  input  logic                        axi_pend_i,
  input  logic                        axi_err_i,
  output logic                        rd_valid_o,
  output logic [IDX_W-1:0]            rd_idx_o,
  input  logic                        rd_done_i,
  output logic                        wr_valid_o,
  output logic [IDX_W-1:0]            wr_idx_o,
  input  logic                        wr_done_i,
  output logic                        active_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [1:0]                  err_code_o,
  output logic [IDX_W:0]              desc_cnt_o,
  output logic                        clear_o
);

  typedef enum logic [2:0] {StIdle, StCfg, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_DESC-1:0] eligible;
  logic [NUM_DESC-1:0] rd_mask_q, wr_mask_q;
  logic                abort_q;
  logic                error_q;
  logic [1:0]          err_code_q;
  logic [IDX_W:0]      desc_cnt_q;
  logic                rd_found, wr_found;
  logic [IDX_W-1:0]    rd_pick, wr_pick;
  logic                rd_acc, wr_acc, all_written, wdog_to, run_end;
  logic                err_set;
  logic [1:0]          err_val;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_DESC; i++) begin
      eligible[i] = desc_en_i[i] && (desc_bytes_i[i*BYTES_W +: BYTES_W] != '0);
    end
  end

  // Scan from the top so the lowest qualifying slot is the one left standing.
  always_comb begin
    rd_found = 1'b0;
    rd_pick  = '0;
    wr_found = 1'b0;
    wr_pick  = '0;
    for (int i = NUM_DESC - 1; i >= 0; i--) begin
      if (eligible[i] && !rd_mask_q[i]) begin
        rd_found = 1'b1;
        rd_pick  = IDX_W'(i);
      end
      if (eligible[i] && !wr_mask_q[i] && rd_mask_q[i]) begin
        wr_found = 1'b1;
        wr_pick  = IDX_W'(i);
      end
    end
  end

  assign all_written = ((eligible & ~wr_mask_q) == '0);
  assign run_end     = (state_q == StDone) && !go_i;

`ifdef DMA_SCHED_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (!(state_q == StRun || state_q == StDrain) || (state_q != state_d) ||
                 rd_done_i || wr_done_i) begin
      wdog_q <= '0;
    end else if (wdog_q != '1) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_to = (state_q == StRun || state_q == StDrain) && (wdog_q == '1);
`else
  // Never true: WDOG_W only has meaning when the watchdog is built in.
  assign wdog_to = (WDOG_W == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_req_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (go_i) state_d = StCfg;
      StCfg:   state_d = (!abort_req_i && (|eligible)) ? StRun : StDone;
      StRun: begin
        if (abort_req_i || (axi_err_i && err_stop_i) || wdog_to) state_d = StDrain;
        else if (all_written && !axi_pend_i)                      state_d = StDone;
      end
      StDrain: if (!axi_pend_i || wdog_to) state_d = StDone;
      StDone:  if (!go_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    active_o   = (state_q == StRun) || (state_q == StDrain);
    done_o     = (state_q == StDone);
    clear_o    = run_end;
    rd_valid_o = (state_q == StRun) && !abort_q && rd_found;
    wr_valid_o = (state_q == StRun) && !abort_q && wr_found;
    rd_idx_o   = rd_valid_o ? rd_pick : '0;
    wr_idx_o   = wr_valid_o ? wr_pick : '0;
    error_o    = error_q;
    err_code_o = err_code_q;
    desc_cnt_o = desc_cnt_q;
  end

  assign rd_acc = rd_done_i && rd_valid_o;
  assign wr_acc = wr_done_i && wr_valid_o;

  // When causes coincide, AXI is recorded ahead of abort ahead of watchdog.
  always_comb begin
    err_set = 1'b1;
    err_val = 2'd0;
    if (axi_err_i && (state_q != StIdle)) begin
      err_val = 2'd1;
    end else if (abort_req_i && (state_q == StCfg || state_q == StRun)) begin
      err_val = 2'd2;
    end else if (wdog_to) begin
      err_val = 2'd3;
    end else begin
      err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else if (run_end) begin
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else if (err_set) begin
      error_q <= 1'b1;
      if (err_code_q == 2'd0) err_code_q <= err_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_mask_q  <= '0;
      wr_mask_q  <= '0;
      desc_cnt_q <= '0;
    end else if (run_end) begin
      rd_mask_q  <= '0;
      wr_mask_q  <= '0;
      desc_cnt_q <= '0;
    end else begin
      if (rd_acc) rd_mask_q[rd_pick] <= 1'b1;
      if (wr_acc) wr_mask_q[wr_pick] <= 1'b1;
      if (wr_acc && (desc_cnt_q != (IDX_W+1)'(NUM_DESC))) desc_cnt_q <= desc_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: directed scenarios plus randomized runs checked against a
// queue-based model of the read/write ordering rules.
module tb_dma_desc_sched;

  logic         clk, rst, go, abort_req, err_stop;
  logic [3:0]   desc_en;
  logic [127:0] desc_bytes;
  logic         axi_pend, axi_err, rd_done, wr_done;
  logic         rd_valid, wr_valid, active, done, error, clear;
  logic [1:0]   rd_idx, wr_idx, err_code;
  logic [2:0]   desc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dma_desc_sched #(.NUM_DESC(4), .BYTES_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .go_i        (go),
    .abort_req_i (abort_req),
    .err_stop_i  (err_stop),
    .desc_en_i   (desc_en),
    .desc_bytes_i(desc_bytes),
    .axi_pend_i  (axi_pend),
    .axi_err_i   (axi_err),
    .rd_valid_o  (rd_valid),
    .rd_idx_o    (rd_idx),
    .rd_done_i   (rd_done),
    .wr_valid_o  (wr_valid),
    .wr_idx_o    (wr_idx),
    .wr_done_i   (wr_done),
    .active_o    (active),
    .done_o      (done),
    .error_o     (error),
    .err_code_o  (err_code),
    .desc_cnt_o  (desc_cnt),
    .clear_o     (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From IDLE: raise go, check the CFG cycle; returns at the negedge of the following state.
  task automatic start_run(input logic [3:0] en, input logic [127:0] bytes);
    desc_en    = en;
    desc_bytes = bytes;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    check("cfg_active", active, 0);
    check("cfg_done", done, 0);
    check("cfg_rd_valid", rd_valid, 0);
    check("cfg_wr_valid", wr_valid, 0);
    @(negedge clk);
  endtask

  // In DONE: drop go, expect the clear pulse and a clean IDLE afterwards.
  task automatic finish_run();
    check("done_clear_held", clear, 0);
    go        = 1'b0;
    abort_req = 1'b0;
    #1;
    check("done_clear_pulse", clear, 1);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_cnt", desc_cnt, 0);
    check("idle_error", error, 0);
    check("idle_code", err_code, 0);
    check("idle_clear", clear, 0);
  endtask

  // Full run with random done pulses (spurious ones included); optionally one logged AXI error.
  task automatic run_full(input logic [3:0] en, input logic [127:0] bytes, input bit inject_err);
    int  elig[$];
    int  rd_n, wr_n, cyc, n;
    bit  fin, rdd, wrd, pend, exp_rv, exp_wv;
    elig = {};
    for (int i = 0; i < 4; i++) begin
      if (en[i] && (bytes[i*32 +: 32] != 32'd0)) elig.push_back(i);
    end
    n    = elig.size();
    rd_n = 0;
    wr_n = 0;
    cyc  = 0;
    fin  = 1'b0;
    start_run(en, bytes);
    if (n == 0) begin
      check("empty_done", done, 1);
      check("empty_rd_valid", rd_valid, 0);
      check("empty_wr_valid", wr_valid, 0);
      check("empty_error", error, 0);
    end else begin
      while (!fin && cyc < 300) begin
        exp_rv = (rd_n < n);
        exp_wv = (wr_n < rd_n);
        check("run_active", active, 1);
        check("run_done", done, 0);
        check("run_rd_valid", rd_valid, exp_rv);
        check("run_wr_valid", wr_valid, exp_wv);
        if (exp_rv) check("run_rd_idx", rd_idx, elig[rd_n]);
        if (exp_wv) check("run_wr_idx", wr_idx, elig[wr_n]);
        check("run_cnt", desc_cnt, wr_n);
        rdd      = ($urandom_range(0, 1) == 1);
        wrd      = ($urandom_range(0, 1) == 1);
        pend     = ($urandom_range(0, 3) == 0);
        rd_done  = rdd;
        wr_done  = wrd;
        axi_pend = pend;
        err_stop = 1'b0;
        axi_err  = inject_err && (cyc == 0);
        fin      = (wr_n == n) && !pend;
        if (rdd && exp_rv) rd_n++;
        if (wrd && exp_wv) wr_n++;
        cyc++;
        @(negedge clk);
      end
      check("run_finished", fin, 1);
      rd_done  = 1'b0;
      wr_done  = 1'b0;
      axi_pend = 1'b0;
      axi_err  = 1'b0;
      check("end_done", done, 1);
      check("end_active", active, 0);
      check("end_cnt", desc_cnt, n);
      check("end_error", error, inject_err);
      check("end_code", err_code, inject_err ? 1 : 0);
    end
    finish_run();
  endtask

  initial begin
    rst        = 1'b0;
    go         = 1'b0;
    abort_req  = 1'b0;
    err_stop   = 1'b0;
    desc_en    = '0;
    desc_bytes = '0;
    axi_pend   = 1'b0;
    axi_err    = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_error", error, 0);
    check("rst_code", err_code, 0);
    check("rst_cnt", desc_cnt, 0);
    check("rst_clear", clear, 0);
    rst = 1'b1;

    // Sparse enables: reads 0,1,3 and writes trail them.
    run_full(4'b1011, {4{32'd64}}, 1'b0);
    // Nothing enabled, then enabled slots with zero byte counts.
    run_full(4'b0000, {4{32'd64}}, 1'b0);
    run_full(4'b1111, {4{32'd0}}, 1'b0);

    // Abort with the AXI side still busy for five DRAIN cycles.
    start_run(4'b1111, {4{32'd16}});
    check("abort_pre_rd_valid", rd_valid, 1);
    check("abort_pre_rd_idx", rd_idx, 0);
    abort_req = 1'b1;
    axi_pend  = 1'b1;
    @(negedge clk);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_wr_valid", wr_valid, 0);
    check("abort_active", active, 1);
    check("abort_error", error, 1);
    check("abort_code", err_code, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_active", active, 1);
      check("drain_done", done, 0);
    end
    axi_pend = 1'b0;
    @(negedge clk);
    check("drain_exit_done", done, 1);
    check("drain_exit_code", err_code, 2);
    finish_run();

    // AXI error with err_stop set forces DRAIN.
    start_run(4'b0110, {4{32'd8}});
    check("estop_rd_idx", rd_idx, 1);
    axi_err  = 1'b1;
    err_stop = 1'b1;
    @(negedge clk);
    axi_err  = 1'b0;
    err_stop = 1'b0;
    check("estop_active", active, 1);
    check("estop_rd_valid", rd_valid, 0);
    check("estop_error", error, 1);
    check("estop_code", err_code, 1);
    @(negedge clk);
    check("estop_done", done, 1);
    check("estop_cnt", desc_cnt, 0);
    finish_run();

    // AXI error only logged: the run still completes.
    run_full(4'b1101, {32'd4, 32'd0, 32'd4, 32'd4}, 1'b1);

    // Same-cycle read and write completion.
    start_run(4'b0011, {4{32'd32}});
    rd_done = 1'b1;
    @(negedge clk);
    check("same_wr_valid", wr_valid, 1);
    check("same_rd_idx", rd_idx, 1);
    wr_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    wr_done = 1'b0;
    check("same_cnt", desc_cnt, 1);
    check("same_rd_valid", rd_valid, 0);
    check("same_wr_idx", wr_idx, 1);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    rst = 1'b0;
    #1;
    check("arst_active", active, 0);
    check("arst_wr_valid", wr_valid, 0);
    check("arst_cnt", desc_cnt, 0);
    check("arst_done", done, 0);
    go = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_idle_active", active, 0);

    for (int t = 0; t < 10; t++) begin
      logic [3:0]   en;
      logic [127:0] bytes;
      en = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        bytes[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
      end
      run_full(en, bytes, ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
